arith_engine: RTL and testbench

ARITH_ENGINE -- requirements
Module: arith_engine

---
 rtl/arith_pkg.sv | 20 ++
 rtl/shift_add_mul.sv | 61 ++++++
 rtl/arith_engine.sv | 112 +++++++++++
 tb/tb_arith_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared opcode and FSM state encodings for the arithmetic engine.
`default_nettype none

package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier, one multiplier bit per cycle.
// o_done/o_product are combinational during the final iteration, so the caller registers the finished product on that same edge.
`default_nettype none

module shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_partial;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_next_partial;

  assign w_addend       = r_mplier[0] ? r_mcand : '0;
  assign w_next_partial = r_partial + w_addend;

  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = w_next_partial;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_partial <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= CW'(WIDTH - 1);
      r_mcand   <= {{WIDTH{1'b0}}, i_a};
      r_mplier  <= i_b;
      r_partial <= '0;
    end else if (r_busy) begin
      r_partial <= w_next_partial;
      r_mplier  <= r_mplier >> 1;
      r_mcand   <= r_mcand << 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arith_engine.sv
// Arithmetic engine: single-cycle ADD/SUB, iterative MUL and multiply-accumulate.
`default_nettype none

module arith_engine
  import arith_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RES_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  v1,
  input  logic [WIDTH-1:0]  v2,
  input  logic [1:0]        opcode,
  output logic [RES_W-1:0]  ans,
  output logic              out_valid
);

  if ((WIDTH < 2) || (WIDTH > 16) || (RES_W < 2 * WIDTH + 1)) begin : g_param_check
    $error("arith_engine: WIDTH must be 2..16 and RES_W >= 2*WIDTH+1");
  end

  state_e             r_state;
  op_e                r_op;
  logic [RES_W-1:0]   r_acc;
  logic [RES_W-1:0]   r_ans;
  logic               r_out_valid;

  op_e                w_op;
  logic               w_accept;
  logic               w_start;
  logic               w_done;
  logic [2*WIDTH-1:0] w_product;
  logic [RES_W-1:0]   w_product_ext;
  logic [RES_W-1:0]   w_sum;
  logic [RES_W-1:0]   w_diff;
  logic [RES_W-1:0]   w_mac;

  assign w_op     = op_e'(opcode);
  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && ((w_op == OP_MUL) || (w_op == OP_MAC));

  assign w_sum         = {{(RES_W-WIDTH){1'b0}}, v1} + {{(RES_W-WIDTH){1'b0}}, v2};
  assign w_diff        = {{(RES_W-WIDTH){1'b0}}, v1} - {{(RES_W-WIDTH){1'b0}}, v2};
  assign w_product_ext = {{(RES_W-2*WIDTH){1'b0}}, w_product};
  assign w_mac         = r_acc + w_product_ext;

  shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock     (clock),
    .reset     (reset),
    .i_start   (w_start),
    .i_a       (v1),
    .i_b       (v2),
    .o_done    (w_done),
    .o_product (w_product)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_acc       <= '0;
      r_ans       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= w_op;
            case (w_op)
              OP_ADD: begin
                r_ans       <= w_sum;
                r_out_valid <= 1'b1;
              end
              OP_SUB: begin
                r_ans       <= w_diff;
                r_out_valid <= 1'b1;
              end
              default: r_state <= ST_MUL;
            endcase
          end
        end
        ST_MUL: begin
          // Final iteration: product is valid combinationally, commit it now.
          if (w_done) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
            if (r_op == OP_MAC) begin
              r_acc <= w_mac;
              r_ans <= w_mac;
            end else begin
              r_ans <= w_product_ext;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ans       = r_ans;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_arith_engine.sv
// Directed self-checking bench for arith_engine (WIDTH=4, RES_W=16).
`default_nettype none

module tb_arith_engine;

  localparam int WIDTH = 4;
  localparam int RES_W = 16;

  localparam logic [1:0] C_ADD = 2'b00;
  localparam logic [1:0] C_MUL = 2'b01;
  localparam logic [1:0] C_SUB = 2'b10;
  localparam logic [1:0] C_MAC = 2'b11;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] v1 = '0;
  logic [WIDTH-1:0] v2 = '0;
  logic [1:0]       opcode = 2'b00;
  logic [RES_W-1:0] ans;
  logic             out_valid;

  int total = 0;
  int bad   = 0;

  arith_engine #(
    .WIDTH (WIDTH),
    .RES_W (RES_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v1        (v1),
    .v2        (v2),
    .opcode    (opcode),
    .ans       (ans),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one operation for a single accept edge; returns just after that edge.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    opcode   = op;
    v1       = a;
    v2       = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [31:0] exp);
    int n;
    issue(op, a, b);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(WIDTH));
    check({tag, "_ans"}, 32'(ans), exp);
  endtask

  initial begin
    int ov_cnt;
    int rdy_low;
    int first_ov;

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    check("rst_ans", 32'(ans), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);

    // ADD 9+7 then hold
    issue(C_ADD, 4'd9, 4'd7);
    check("add_ov", 32'(out_valid), 32'd1);
    check("add_ans", 32'(ans), 32'd16);
    tick();
    check("add_ov_drop", 32'(out_valid), 32'd0);
    check("add_hold", 32'(ans), 32'd16);

    issue(C_ADD, 4'd15, 4'd15);
    check("add_max", 32'(ans), 32'd30);

    // SUB wraps modulo 2^16
    issue(C_SUB, 4'd3, 4'd5);
    check("sub_ov", 32'(out_valid), 32'd1);
    check("sub_ans", 32'(ans), 32'hFFFE);
    issue(C_SUB, 4'd0, 4'd15);
    check("sub_0_15", 32'(ans), 32'hFFF1);
    issue(C_SUB, 4'd12, 4'd5);
    check("sub_pos", 32'(ans), 32'd7);
    tick();

    // MUL 15*15 with in_valid pulses ignored while busy
    issue(C_MUL, 4'd15, 4'd15);
    ov_cnt = 0; rdy_low = 0; first_ov = -1;
    for (int t = 0; t < 9; t++) begin
      if (!in_ready) rdy_low++;
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = t;
      end
      in_valid = (t < 3);
      opcode   = C_ADD;
      v1       = 4'd1;
      v2       = 4'd1;
      tick();
    end
    in_valid = 1'b0;
    check("mul_rdy_low", 32'(rdy_low), 32'd4);
    check("mul_first_ov", 32'(first_ov), 32'd4);
    check("mul_ov_count", 32'(ov_cnt), 32'd1);
    check("mul_ans", 32'(ans), 32'd225);

    run_mul("mul_13x11", C_MUL, 4'd13, 4'd11, 32'd143);
    run_mul("mul_0x9", C_MUL, 4'd0, 4'd9, 32'd0);

    // MAC accumulation; intervening MUL leaves acc alone
    reset = 1'b1; tick(); reset = 1'b0;
    run_mul("mac1", C_MAC, 4'd15, 4'd15, 32'd225);
    run_mul("mac2", C_MAC, 4'd15, 4'd15, 32'd450);
    run_mul("mul_mid", C_MUL, 4'd2, 4'd3, 32'd6);
    run_mul("mac3", C_MAC, 4'd15, 4'd15, 32'd675);
    reset = 1'b1; tick(); reset = 1'b0;
    run_mul("mac_after_rst", C_MAC, 4'd2, 4'd3, 32'd6);

    // Reset two cycles into a MUL aborts it
    issue(C_MUL, 4'd15, 4'd15);
    tick();
    reset = 1'b1;
    tick();
    check("abort_ov", 32'(out_valid), 32'd0);
    check("abort_ans", 32'(ans), 32'd0);
    check("abort_rdy", 32'(in_ready), 32'd1);
    reset = 1'b0;
    ov_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (out_valid) ov_cnt++;
    end
    check("abort_no_ov", 32'(ov_cnt), 32'd0);

    // Reset beats a simultaneous accept
    issue(C_ADD, 4'd7, 4'd1);
    reset    = 1'b1;
    in_valid = 1'b1;
    opcode   = C_ADD;
    v1       = 4'd5;
    v2       = 4'd5;
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    check("rstprio_ov", 32'(out_valid), 32'd0);
    check("rstprio_ans", 32'(ans), 32'd0);
    tick();
    check("rstprio_ov2", 32'(out_valid), 32'd0);
    check("rstprio_ans2", 32'(ans), 32'd0);

    // Back-to-back ADDs every cycle
    in_valid = 1'b1;
    opcode   = C_ADD;
    for (int k = 1; k <= 3; k++) begin
      v1 = WIDTH'(k);
      v2 = WIDTH'(k);
      tick();
      check($sformatf("b2b%0d_ov", k), 32'(out_valid), 32'd1);
      check($sformatf("b2b%0d_ans", k), 32'(ans), 32'(2 * k));
    end
    in_valid = 1'b0;
    tick();
    check("b2b_end_ov", 32'(out_valid), 32'd0);
    check("b2b_end_ans", 32'(ans), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
